// File: rtl/mips_main_ctrl_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller drives the enables and mux selects; the datapath returns op and zero.
interface mips_main_ctrl_if;
    // Datapath to controller
    logic [5:0] op;
    logic       zero;

    // Controller to datapath
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op,
        input  zero,
        output pcen,
        output irwrite,
        output memwrite,
        output iord,
        output regwrite,
        output regdst,
        output memtoreg,
        output alusrca,
        output alusrcb,
        output aluop,
        output pcsrc,
        output illegal,
        output state
    );

    modport slave (
        output op,
        output zero,
        input  pcen,
        input  irwrite,
        input  memwrite,
        input  iord,
        input  regwrite,
        input  regdst,
        input  memtoreg,
        input  alusrca,
        input  alusrcb,
        input  aluop,
        input  pcsrc,
        input  illegal,
        input  state
    );
endinterface

// File: rtl/mips_main_ctrl.sv
// Moore main control FSM of the multicycle MIPS core.
// All outputs decode the state register; only pcen also looks at the ALU zero flag.
module mips_main_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    mips_main_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q;
    state_e state_d;

    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;

    // op decode flags, only meaningful while the IR holds the instruction
    logic is_lw;
    logic is_sw;
    logic is_rtype;
    logic is_beq;
    logic is_addi;
    logic is_j;

    assign is_lw    = (bus.op == OP_LW);
    assign is_sw    = (bus.op == OP_SW);
    assign is_rtype = (bus.op == OP_RTYPE);
    assign is_beq   = (bus.op == OP_BEQ);
    assign is_addi  = (bus.op == OP_ADDI);
    assign is_j     = (bus.op == OP_J);

    // State register; reset always lands in FETCH, even from HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: dispatch on op in DECODE, then walk the instruction
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEMADR;
                end else if (is_rtype) begin
                    state_d = S_RTYPEEX;
                end else if (is_beq) begin
                    state_d = S_BEQEX;
                end else if (is_addi) begin
                    state_d = S_ADDIEX;
                end else if (is_j) begin
                    state_d = S_JEX;
                end else if (TRAP_ON_ILLEGAL) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (is_lw) begin
                    state_d = S_MEMRD;
                end else if (is_sw) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
            end
            S_RTYPEEX: begin
                state_d = S_RTYPEWB;
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_MEMWB,
            S_MEMWR,
            S_RTYPEWB,
            S_BEQEX,
            S_ADDIWB,
            S_JEX: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Per-state control decode; everything is held low while reset is high
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    iord = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RTYPEWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_JEX: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
                S_HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    // Drive the bundle; pcen is the only output that sees zero
    always_comb begin
        bus.pcen     = pcwrite | (branch & bus.zero);
        bus.irwrite  = irwrite;
        bus.memwrite = memwrite;
        bus.iord     = iord;
        bus.regwrite = regwrite;
        bus.regdst   = regdst;
        bus.memtoreg = memtoreg;
        bus.alusrca  = alusrca;
        bus.alusrcb  = alusrcb;
        bus.aluop    = aluop;
        bus.pcsrc    = pcsrc;
        bus.illegal  = illegal;
        bus.state    = reset ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl, both trap settings.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_mips_main_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    mips_main_ctrl_if if0();
    mips_main_ctrl_if if1();

    mips_main_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0.master)
    );

    mips_main_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.master)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal;
    } obs_t;

    typedef int iq_t[$];

    obs_t q0[$];
    obs_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    obs_t a0;
    obs_t a1;

    assign a0 = {if0.state, if0.pcen, if0.irwrite, if0.memwrite, if0.iord,
                 if0.regwrite, if0.regdst, if0.memtoreg, if0.alusrca,
                 if0.alusrcb, if0.aluop, if0.pcsrc, if0.illegal};
    assign a1 = {if1.state, if1.pcen, if1.irwrite, if1.memwrite, if1.iord,
                 if1.regwrite, if1.regdst, if1.memtoreg, if1.alusrca,
                 if1.alusrcb, if1.aluop, if1.pcsrc, if1.illegal};

    // Reference: control word each state must present
    function automatic obs_t expect_of(input int st, input logic z);
        obs_t e;
        bit   pw;
        bit   br;
        e  = '0;
        pw = 1'b0;
        br = 1'b0;
        e.st = st[3:0];
        case (st)
            0:  begin e.irwrite = 1; pw = 1; e.alusrcb = 2'b01; end
            1:  begin e.alusrcb = 2'b11; end
            2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3:  begin e.iord = 1; end
            4:  begin e.regwrite = 1; e.memtoreg = 1; end
            5:  begin e.iord = 1; e.memwrite = 1; end
            6:  begin e.alusrca = 1; e.aluop = 2'b10; end
            7:  begin e.regwrite = 1; e.regdst = 1; end
            8:  begin e.alusrca = 1; e.aluop = 2'b01;
                      e.pcsrc = 2'b01; br = 1; end
            9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            10: begin e.regwrite = 1; end
            11: begin pw = 1; e.pcsrc = 2'b10; end
            12: begin e.illegal = 1; end
            default: begin end
        endcase
        e.pcen = pw | (br & z);
        return e;
    endfunction

    // Reference: state walk of one instruction, from FETCH to retirement
    function automatic iq_t seq_of(input logic [5:0] o);
        iq_t s;
        case (o)
            6'b100011: s = '{0, 1, 2, 3, 4};
            6'b101011: s = '{0, 1, 2, 5};
            6'b000000: s = '{0, 1, 6, 7};
            6'b001000: s = '{0, 1, 9, 10};
            6'b000100: s = '{0, 1, 8};
            6'b000010: s = '{0, 1, 11};
            default:   s = '{0, 1};
        endcase
        return s;
    endfunction

    // One clock of stimulus on DUT w; the other DUT is held in reset
    task automatic cyc(input int w, input bit r, input logic [5:0] o,
                       input logic z, input int st);
        obs_t e;
        @(posedge clk);
        #1;
        cyc_no++;
        e = r ? obs_t'(0) : expect_of(st, z);
        if (w == 0) begin
            rst0 = r;
            if0.op = o;
            if0.zero = z;
            rst1 = 1'b1;
            if1.op = 6'($urandom);
            if1.zero = 1'($urandom);
            q0.push_back(e);
            q1.push_back(obs_t'(0));
        end else begin
            rst1 = r;
            if1.op = o;
            if1.zero = z;
            rst0 = 1'b1;
            if0.op = 6'($urandom);
            if0.zero = 1'($urandom);
            q1.push_back(e);
            q0.push_back(obs_t'(0));
        end
    endtask

    // zsel < 0 means random zero per cycle; rst_at >= 0 aborts with reset there
    task automatic run_instr(input int w, input logic [5:0] o,
                             input int zsel, input int rst_at);
        iq_t  s;
        logic z;
        s = seq_of(o);
        foreach (s[i]) begin
            z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
            if (i == rst_at) begin
                cyc(w, 1'b1, o, z, 0);
                return;
            end
            cyc(w, 1'b0, o, z, s[i]);
        end
    endtask

    task automatic do_reset(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(w, 1'b1, 6'($urandom), 1'($urandom), 0);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        obs_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            n_chk++;
            if (a0 !== e) begin
                n_fail++;
                $display("FAIL dut0 cyc %0d: got st=%0d word=%h want st=%0d word=%h",
                         cyc_no, a0.st, a0, e.st, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            n_chk++;
            if (a1 !== e) begin
                n_fail++;
                $display("FAIL dut1 cyc %0d: got st=%0d word=%h want st=%0d word=%h",
                         cyc_no, a1.st, a1, e.st, e);
            end
        end
    end

    logic [5:0] ops [8];
    logic [5:0] o;
    int         ra;

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b111111, 6'b010101};
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.op = 6'd0;
        if0.zero = 1'b0;
        if1.op = 6'd0;
        if1.zero = 1'b0;

        do_reset(0, 3);
        run_instr(0, 6'b100011, -1, -1);
        run_instr(0, 6'b101011, -1, -1);
        run_instr(0, 6'b000000, 1, -1);
        run_instr(0, 6'b000100, 1, -1);
        run_instr(0, 6'b000100, 0, -1);
        run_instr(0, 6'b000010, -1, -1);
        run_instr(0, 6'b001000, -1, -1);
        run_instr(0, 6'b111111, -1, -1);
        run_instr(0, 6'b100011, -1, 3);
        run_instr(0, 6'b000000, -1, -1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                o = 6'($urandom);
            end else begin
                o = ops[$urandom_range(0, 7)];
            end
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(0, o, -1, ra);
        end

        do_reset(1, 3);
        run_instr(1, 6'b001000, -1, -1);
        run_instr(1, 6'b000100, 1, -1);
        run_instr(1, 6'b111111, -1, -1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1'b0, 6'b111111, 1'($urandom), 12);
        end
        do_reset(1, 3);
        run_instr(1, 6'b100011, -1, -1);
        run_instr(1, 6'b011111, -1, -1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1'b0, 6'($urandom), 1'($urandom), 12);
        end
        do_reset(1, 1);
        run_instr(1, 6'b101011, -1, -1);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (q0.size() + q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0",
                     q0.size() + q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
Main control FSM for the 32-bit multicycle MIPS core. It sequences the datapath registers (PC, IR, data, A/B, ALUOut) and the memory, register-file and ALU muxes, one instruction at a time. The block is Moore: every control output is a function of the state register only, except pcen, which also depends on the ALU zero flag. It sits beside the datapath, takes op and zero from it, and drives the enables of the datapath enable-flops.

Parameters:
TRAP_ON_ILLEGAL, 0, 1: unknown opcode enters HALT until reset; 0: unknown opcode returns to FETCH (treated as a NOP).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
op  input  6  IR[31:26], sampled in DECODE
zero  input  1  ALU zero flag, used in BEQEX only
pcen  output  1  PC register enable = pcwrite | (branch & zero)
irwrite  output  1  IR register enable
memwrite  output  1  memory write strobe
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
regwrite  output  1  register-file write enable
regdst  output  1  write register select: 0 = rt, 1 = rd
memtoreg  output  1  write-data select: 0 = ALUOut, 1 = data register
alusrca  output  1  ALU A select: 0 = PC, 1 = A register
alusrcb  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
aluop  output  2  00 = add, 01 = sub, 10 = decode by funct
pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  output  1  high in HALT
state  output  4  current state code, debug

Behaviour:
- State register updates on posedge clk. On any edge with reset=1 the next state is FETCH (0), regardless of the current state, including mid-instruction or HALT.
- While reset=1, every output is forced to 0 and state reads 0. No write strobe may leak during reset.
- State codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 12
  - Codes 13-15 go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
  - DECODE, any other op -> HALT if TRAP_ON_ILLEGAL=1, else FETCH.
  - MEMADR -> MEMRD if op=100011, MEMWR if op=101011.
  - MEMRD -> MEMWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
  - RTYPEEX -> RTYPEWB. ADDIEX -> ADDIWB.
  - HALT -> HALT.
- op must be held stable by the IR from DECODE until the instruction retires. The block does not latch op.
- Per-state outputs (any output not listed is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcwrite=1, pcsrc=10.
  - HALT: illegal=1.
- pcen is combinational: pcen = pcwrite | (branch & zero). zero is ignored outside BEQEX.
- Cycles per instruction (FETCH through the last state): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal NOP 2.

Test Plan:
- Reset for 3 cycles from an arbitrary state, then release -> all outputs 0 while reset=1. First cycle after release: state=0, irwrite=1, pcen=1, alusrcb=01.
- op=100011 -> state sequence 0,1,2,3,4,0. memtoreg=1 and regwrite=1 only in state 4; iord=1 only in state 3.
- op=101011, then op=000000 -> sw gives 0,1,2,5,0 with memwrite=1 in one cycle only. R-type gives 0,1,6,7,0 with aluop=10 in state 6, and regdst=1, regwrite=1 in state 7.
- op=000100 with zero=1, then with zero=0 -> BEQEX gives pcen=1, pcsrc=01 in the first case and pcen=0 in the second. zero=1 in state 6 must leave pcen=0.
- op=000010 and op=001000 -> j gives 0,1,11,0 with pcen=1, pcsrc=10. addi gives 0,1,9,10,0 with alusrcb=10 in state 9 and regwrite=1, regdst=0 in state 10.
- op=111111 -> with TRAP_ON_ILLEGAL=0: 0,1,0 and no strobes in state 1. With TRAP_ON_ILLEGAL=1: state stays 12 with illegal=1 for 10 or more cycles, and reset returns to 0. Asserting reset while in state 3 -> state 0 next edge, and no regwrite is issued.
